seq_pattern_gen: RTL and testbench



---
 rtl/seq_pattern_gen.sv | 129 ++++++++++++
 tb/tb_seq_pattern_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: emits a captured pattern MSB-first, len*rep bits
// back-to-back, and keeps a reference count of overlapping "101" occurrences.
module seq_pattern_gen #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [MAX_LEN-1:0] pat_in,
   input  logic [LEN_W-1:0]   len_in,
   input  logic [CNT_W-1:0]   rep_in,
   output logic               seq_out,
   output logic               seq_valid,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [CNT_W-1:0]   exp_hits
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [IDX_W-1:0]   idx_q;
   logic [CNT_W-1:0]   rep_q;
   logic [1:0]         hist_q;
   logic [CNT_W-1:0]   hits_q;
   logic               seq_out_q, seq_valid_q, busy_q, done_q, err_q;

   logic               args_ok;
   logic [LEN_W-1:0]   len_m1_in, len_m1_q;
   logic               bit_d;
   logic [CNT_W-1:0]   hits_d;

   assign args_ok   = (len_in != '0) && (len_in <= LEN_W'(MAX_LEN)) && (rep_in != '0);
   assign len_m1_in = len_in - LEN_W'(1);
   assign len_m1_q  = len_q - LEN_W'(1);
   assign bit_d     = pat_q[idx_q];
   // "101" completes when history holds "10" and the new bit is 1; saturating count
   assign hits_d    = (hist_q == 2'b10 && bit_d && hits_q != '1) ? hits_q + CNT_W'(1) : hits_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pat_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         rep_q       <= '0;
         hist_q      <= '0;
         hits_q      <= '0;
         seq_out_q   <= 1'b0;
         seq_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               seq_out_q   <= 1'b0;
               seq_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               if (start) begin
                  if (args_ok) begin
                     pat_q   <= pat_in;
                     len_q   <= len_in;
                     rep_q   <= rep_in;
                     idx_q   <= len_m1_in[IDX_W-1:0];
                     hist_q  <= '0;
                     hits_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_SEND;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_SEND: begin
               seq_out_q   <= bit_d;
               seq_valid_q <= 1'b1;
               busy_q      <= 1'b1;
               hist_q      <= {hist_q[0], bit_d};
               hits_q      <= hits_d;
               if (idx_q == '0) begin
                  if (rep_q > CNT_W'(1)) begin
                     rep_q <= rep_q - CNT_W'(1);
                     idx_q <= len_m1_q[IDX_W-1:0];
                  end else begin
                     state_q <= S_DONE;
                  end
               end else begin
                  idx_q <= idx_q - IDX_W'(1);
               end
            end
            S_DONE: begin
               seq_out_q   <= 1'b0;
               seq_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               seq_out_q   <= 1'b0;
               seq_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign seq_out   = seq_out_q;
   assign seq_valid = seq_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign exp_hits  = hits_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: vector table plus hand-written
// sequences for mid-run start and mid-run reset.
module tb_seq_pattern_gen;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] pat_in;
   logic [4:0]  len_in;
   logic [7:0]  rep_in;
   logic        seq_out, seq_valid, busy, done, err;
   logic [7:0]  exp_hits;

   int n_tests = 0;
   int n_fail  = 0;

   seq_pattern_gen #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .pat_in(pat_in), .len_in(len_in),
      .rep_in(rep_in), .seq_out(seq_out), .seq_valid(seq_valid), .busy(busy),
      .done(done), .err(err), .exp_hits(exp_hits)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, start;
      logic [15:0] pat;
      logic [4:0]  len;
      logic [7:0]  rep;
      logic        so, sv, bz, dn, er;
      logic [7:0]  hits;
   } vec_t;

   function automatic vec_t mk(logic r, logic s, logic [15:0] p, logic [4:0] l, logic [7:0] n,
                               logic so, logic sv, logic bz, logic dn, logic er, logic [7:0] h);
      vec_t v;
      v.rst = r; v.start = s; v.pat = p; v.len = l; v.rep = n;
      v.so = so; v.sv = sv; v.bz = bz; v.dn = dn; v.er = er; v.hits = h;
      return v;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(string nm, logic so, logic sv, logic bz, logic dn, logic er, logic [7:0] h);
      chk({nm, ".seq_out"}, int'(seq_out), int'(so));
      chk({nm, ".seq_valid"}, int'(seq_valid), int'(sv));
      chk({nm, ".busy"}, int'(busy), int'(bz));
      chk({nm, ".done"}, int'(done), int'(dn));
      chk({nm, ".err"}, int'(err), int'(er));
      chk({nm, ".exp_hits"}, int'(exp_hits), int'(h));
   endtask

   task automatic drive(logic s, logic [15:0] p, logic [4:0] l, logic [7:0] n);
      start = s; pat_in = p; len_in = l; rep_in = n;
   endtask

   vec_t vt[$];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ones;
      logic [2:0] exp_bits;
      rst = 1'b1;
      drive(0, 0, 0, 0);

      // reset and idle
      vt.push_back(mk(1,0,16'h0,0,0,  0,0,0,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  0,0,0,0,0,0));
      // 101, len 3, rep 1
      vt.push_back(mk(0,1,16'h0005,3,1, 0,0,1,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  1,1,1,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  0,1,1,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  1,1,1,0,0,1));
      vt.push_back(mk(0,0,16'h0,0,0,  0,0,0,1,0,1));
      vt.push_back(mk(0,0,16'h0,0,0,  0,0,0,0,0,1));
      // 10101, overlap counted; start during DONE is ignored
      vt.push_back(mk(0,1,16'h0015,5,1, 0,0,1,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  1,1,1,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  0,1,1,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  1,1,1,0,0,1));
      vt.push_back(mk(0,0,16'h0,0,0,  0,1,1,0,0,1));
      vt.push_back(mk(0,0,16'h0,0,0,  1,1,1,0,0,2));
      vt.push_back(mk(0,1,16'h0002,2,3, 0,0,0,1,0,2));
      vt.push_back(mk(0,0,16'h0,0,0,  0,0,0,0,0,2));
      // 10 x3, history continuous across repetitions
      vt.push_back(mk(0,1,16'h0002,2,3, 0,0,1,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  1,1,1,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  0,1,1,0,0,0));
      vt.push_back(mk(0,0,16'h0,0,0,  1,1,1,0,0,1));
      vt.push_back(mk(0,0,16'h0,0,0,  0,1,1,0,0,1));
      vt.push_back(mk(0,0,16'h0,0,0,  1,1,1,0,0,2));
      vt.push_back(mk(0,0,16'h0,0,0,  0,1,1,0,0,2));
      vt.push_back(mk(0,0,16'h0,0,0,  0,0,0,1,0,2));
      vt.push_back(mk(0,0,16'h0,0,0,  0,0,0,0,0,2));
      // rejected starts: len 0, rep 0, len 17
      vt.push_back(mk(0,1,16'h0005,0,4,  0,0,0,0,1,2));
      vt.push_back(mk(0,0,16'h0,0,0,  0,0,0,0,0,2));
      vt.push_back(mk(0,1,16'h0005,3,0,  0,0,0,0,1,2));
      vt.push_back(mk(0,0,16'h0,0,0,  0,0,0,0,0,2));
      vt.push_back(mk(0,1,16'h0005,17,1, 0,0,0,0,1,2));
      vt.push_back(mk(0,0,16'h0,0,0,  0,0,0,0,0,2));

      foreach (vt[i]) begin
         rst = vt[i].rst;
         drive(vt[i].start, vt[i].pat, vt[i].len, vt[i].rep);
         @(negedge clk);
         chk_all($sformatf("vec%0d", i), vt[i].so, vt[i].sv, vt[i].bz, vt[i].dn, vt[i].er, vt[i].hits);
      end

      // all-ones run with a second start mid-run: stream must be untouched
      drive(1, 16'hFFFF, 16, 2);
      @(negedge clk);
      chk("ones.accept_busy", int'(busy), 1);
      drive(0, 0, 0, 0);
      ones = 0;
      for (int i = 0; i < 32; i++) begin
         if (i == 5) drive(1, 16'h0005, 3, 1);
         if (i == 9) drive(0, 0, 0, 0);
         @(negedge clk);
         if (seq_valid === 1'b1 && seq_out === 1'b1) ones++;
         if (err !== 1'b0) chk($sformatf("ones.err%0d", i), int'(err), 0);
      end
      chk("ones.count", ones, 32);
      chk("ones.hits", int'(exp_hits), 0);
      @(negedge clk);
      chk("ones.done", int'(done), 1);
      chk("ones.busy_end", int'(busy), 0);

      // reset after 4 bits of a 30-bit run
      drive(1, 16'h0005, 3, 10);
      @(negedge clk);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("rst.pre_valid", int'(seq_valid), 1);
      chk("rst.pre_hits", int'(exp_hits), 1);
      #2 rst = 1'b1;
      #1 chk_all("rst.async", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_all($sformatf("rst.idle%0d", i), 0, 0, 0, 0, 0, 0);
      end

      // fresh run after reset
      drive(1, 16'h0005, 3, 1);
      @(negedge clk);
      drive(0, 0, 0, 0);
      exp_bits = 3'b101;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("fresh.bit%0d", i), int'(seq_out), int'(exp_bits[2-i]));
         chk($sformatf("fresh.valid%0d", i), int'(seq_valid), 1);
      end
      @(negedge clk);
      chk_all("fresh.done", 0, 0, 0, 1, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
